// File: rtl/regfile_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter_if
// Bundle of the writeback-arbiter bus signals.
//   alu_valid/alu_addr/alu_data/alu_ready : ALU writeback requester
//   mem_valid/mem_addr/mem_data/mem_ready : load writeback requester
//   we3/wa3/wd3                           : register-file write port (registered)
//   rsv_valid/rsv_addr                    : issue-stage destination reservation
//   pending                               : per-register outstanding-write mask
// Modports: slave = arbiter side, master = requester/environment side.
// ---------------------------------------------------------------------------
interface regfile_wb_arbiter_if;
   logic       alu_valid;
   logic [2:0] alu_addr;
   logic [7:0] alu_data;
   logic       alu_ready;
   logic       mem_valid;
   logic [2:0] mem_addr;
   logic [7:0] mem_data;
   logic       mem_ready;
   logic       we3;
   logic [2:0] wa3;
   logic [7:0] wd3;
   logic       rsv_valid;
   logic [2:0] rsv_addr;
   logic [7:0] pending;

   modport slave (
      input  alu_valid, alu_addr, alu_data,
      input  mem_valid, mem_addr, mem_data,
      input  rsv_valid, rsv_addr,
      output alu_ready, mem_ready,
      output we3, wa3, wd3,
      output pending
   );

   modport master (
      output alu_valid, alu_addr, alu_data,
      output mem_valid, mem_addr, mem_data,
      output rsv_valid, rsv_addr,
      input  alu_ready, mem_ready,
      input  we3, wa3, wd3,
      input  pending
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
// Round-robin arbiter between ALU and load writebacks into a single register
// file write port, with an optional reservation scoreboard.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : regfile_wb_arbiter_if.slave (requesters, write port, reservations,
//         pending mask)
// Build option: define REGFILE_WB_SCOREBOARD_EN to include the reservation
// scoreboard; otherwise pending is tied to zero and rsv_* are ignored.
// ---------------------------------------------------------------------------
module regfile_wb_arbiter (
   input logic                 clk,
   input logic                 rst,
   regfile_wb_arbiter_if.slave bus
);

   // 0: ALU holds priority, 1: mem holds priority
   logic       prio_q;
   logic       alu_hs;
   logic       mem_hs;
   logic       hs;
   logic [2:0] sel_addr;
   logic [7:0] sel_data;
   logic       we3_q;
   logic [2:0] wa3_q;
   logic [7:0] wd3_q;

   // Ready depends only on valids and the pointer, never on the other ready.
   always_comb begin
      bus.alu_ready = 1'b0;
      bus.mem_ready = 1'b0;
      if (rst) begin
         bus.alu_ready = bus.alu_valid && (!bus.mem_valid || !prio_q);
         bus.mem_ready = bus.mem_valid && (!bus.alu_valid || prio_q);
      end
   end

   always_comb begin
      alu_hs   = bus.alu_valid && bus.alu_ready;
      mem_hs   = bus.mem_valid && bus.mem_ready;
      hs       = alu_hs || mem_hs;
      sel_addr = mem_hs ? bus.mem_addr : bus.alu_addr;
      sel_data = mem_hs ? bus.mem_data : bus.alu_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prio_q <= 1'b0;
         we3_q  <= 1'b0;
         wa3_q  <= 3'd0;
         wd3_q  <= 8'h00;
      end else begin
         // x0 writes complete the handshake but never reach the register file
         we3_q <= hs && (sel_addr != 3'd0);
         if (hs) begin
            wa3_q <= sel_addr;
            wd3_q <= sel_data;
         end
         if (alu_hs) begin
            prio_q <= 1'b1;
         end else if (mem_hs) begin
            prio_q <= 1'b0;
         end
      end
   end

   assign bus.we3 = we3_q;
   assign bus.wa3 = wa3_q;
   assign bus.wd3 = wd3_q;

`ifdef REGFILE_WB_SCOREBOARD_EN
   logic [7:0] pending_q;
   logic [7:0] pending_d;

   // Clear first, then set, so a same-register reservation on the write edge wins.
   always_comb begin
      pending_d = pending_q;
      if (hs && (sel_addr != 3'd0)) begin
         pending_d[sel_addr] = 1'b0;
      end
      if (bus.rsv_valid && (bus.rsv_addr != 3'd0)) begin
         pending_d[bus.rsv_addr] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending_q <= 8'h00;
      end else begin
         pending_q <= pending_d;
      end
   end

   assign bus.pending = pending_q;
`else
   logic unused_rsv;
   assign unused_rsv  = ^{bus.rsv_valid, bus.rsv_addr};
   assign bus.pending = 8'h00;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Directed bench for regfile_wb_arbiter. Inputs change 1 time unit after a
// rising edge; outputs are sampled at the same point, away from the edge.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

`ifdef REGFILE_WB_SCOREBOARD_EN
   localparam bit SbEn = 1'b1;
`else
   localparam bit SbEn = 1'b0;
`endif

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_fail;

   regfile_wb_arbiter_if bus ();

   regfile_wb_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_alu(input logic v, input logic [2:0] a, input logic [7:0] d);
      bus.alu_valid = v;
      bus.alu_addr  = a;
      bus.alu_data  = d;
   endtask

   task automatic set_mem(input logic v, input logic [2:0] a, input logic [7:0] d);
      bus.mem_valid = v;
      bus.mem_addr  = a;
      bus.mem_data  = d;
   endtask

   task automatic set_rsv(input logic v, input logic [2:0] a);
      bus.rsv_valid = v;
      bus.rsv_addr  = a;
   endtask

   task automatic check_wr(input string tag, input logic we, input logic [2:0] wa,
                           input logic [7:0] wd);
      check({tag, "_we3"}, {7'd0, bus.we3}, {7'd0, we});
      check({tag, "_wa3"}, {5'd0, bus.wa3}, {5'd0, wa});
      check({tag, "_wd3"}, bus.wd3, wd);
   endtask

   task automatic check_rdy(input string tag, input logic ar, input logic mr);
      check({tag, "_alu_ready"}, {7'd0, bus.alu_ready}, {7'd0, ar});
      check({tag, "_mem_ready"}, {7'd0, bus.mem_ready}, {7'd0, mr});
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      set_alu(1'b0, 3'd0, 8'h00);
      set_mem(1'b0, 3'd0, 8'h00);
      set_rsv(1'b0, 3'd0);
      rst = 1'b1;
      #1 rst = 1'b0;

      // Reset state; ready must stay low even with requests present
      set_alu(1'b1, 3'd3, 8'h77);
      set_mem(1'b1, 3'd2, 8'h66);
      #2;
      check_wr("reset", 1'b0, 3'd0, 8'h00);
      check("reset_pending", bus.pending, 8'h00);
      check_rdy("reset", 1'b0, 1'b0);
      tick();
      check_wr("reset_clk", 1'b0, 3'd0, 8'h00);
      set_alu(1'b0, 3'd0, 8'h00);
      set_mem(1'b0, 3'd0, 8'h00);
      #2 rst = 1'b1;

      // Single ALU write, addr 3 data A5
      tick();
      set_alu(1'b1, 3'd3, 8'hA5);
      #1;
      check_rdy("alu_only", 1'b1, 1'b0);
      tick();
      check_wr("alu_only_wr", 1'b1, 3'd3, 8'hA5);
      set_alu(1'b0, 3'd0, 8'h00);
      tick();
      check_wr("alu_only_idle", 1'b0, 3'd3, 8'hA5);

      // Fresh reset, then both valid for 4 cycles: strict alternation
      rst = 1'b0;
      #2 rst = 1'b1;
      set_alu(1'b1, 3'd1, 8'h11);
      set_mem(1'b1, 3'd2, 8'h22);
      #1;
      check_rdy("rr_c0", 1'b1, 1'b0);
      tick();
      check_wr("rr_c1", 1'b1, 3'd1, 8'h11);
      check_rdy("rr_c1", 1'b0, 1'b1);
      tick();
      check_wr("rr_c2", 1'b1, 3'd2, 8'h22);
      check_rdy("rr_c2", 1'b1, 1'b0);
      tick();
      check_wr("rr_c3", 1'b1, 3'd1, 8'h11);
      check_rdy("rr_c3", 1'b0, 1'b1);
      tick();
      check_wr("rr_c4", 1'b1, 3'd2, 8'h22);
      set_alu(1'b0, 3'd0, 8'h00);
      set_mem(1'b0, 3'd0, 8'h00);
      tick();
      check_wr("rr_idle", 1'b0, 3'd2, 8'h22);

      // mem write to x0: handshake completes, no write enable
      set_mem(1'b1, 3'd0, 8'hFF);
      #1;
      check_rdy("x0", 1'b0, 1'b1);
      tick();
      check_wr("x0_wr", 1'b0, 3'd0, 8'hFF);
      set_mem(1'b0, 3'd0, 8'h00);

      // Pointer holds across valid drops and idle cycles (ALU priority now)
      set_alu(1'b1, 3'd4, 8'h40);
      set_mem(1'b1, 3'd5, 8'h50);
      #1;
      check_rdy("hold_both", 1'b1, 1'b0);
      set_alu(1'b0, 3'd0, 8'h00);
      #1;
      check_rdy("hold_mem_only", 1'b0, 1'b1);
      set_mem(1'b0, 3'd0, 8'h00);
      tick();
      check_wr("hold_idle", 1'b0, 3'd0, 8'hFF);
      set_alu(1'b1, 3'd4, 8'h40);
      set_mem(1'b1, 3'd5, 8'h50);
      #1;
      check_rdy("hold_again", 1'b1, 1'b0);
      set_alu(1'b0, 3'd0, 8'h00);
      set_mem(1'b0, 3'd0, 8'h00);

      // Reservation scoreboard
      tick();
      if (SbEn) begin
         set_rsv(1'b1, 3'd5);
         tick();
         check("sb_set5", bus.pending, 8'h20);
         set_alu(1'b1, 3'd5, 8'h55);
         tick();
         check("sb_same_edge", bus.pending, 8'h20);
         check_wr("sb_same_edge", 1'b1, 3'd5, 8'h55);
         set_rsv(1'b0, 3'd0);
         tick();
         check("sb_clear5", bus.pending, 8'h00);
         set_alu(1'b0, 3'd0, 8'h00);
         set_rsv(1'b1, 3'd0);
         tick();
         check("sb_rsv_x0", bus.pending, 8'h00);
         set_rsv(1'b1, 3'd2);
         tick();
         check("sb_set2", bus.pending, 8'h04);
         set_rsv(1'b1, 3'd3);
         set_alu(1'b1, 3'd2, 8'h22);
         tick();
         check("sb_set3_clr2", bus.pending, 8'h08);
         set_alu(1'b1, 3'd3, 8'h33);
         set_rsv(1'b0, 3'd0);
         tick();
         check("sb_clr3", bus.pending, 8'h00);
         set_alu(1'b1, 3'd3, 8'h34);
         tick();
         check("sb_clr_noop", bus.pending, 8'h00);
         set_alu(1'b0, 3'd0, 8'h00);
      end else begin
         set_rsv(1'b1, 3'd4);
         tick();
         check("nosb_c1", bus.pending, 8'h00);
         set_alu(1'b1, 3'd4, 8'h44);
         tick();
         check("nosb_c2", bus.pending, 8'h00);
         check_wr("nosb_c2", 1'b1, 3'd4, 8'h44);
         set_alu(1'b0, 3'd0, 8'h00);
         tick();
         check("nosb_c3", bus.pending, 8'h00);
         check_wr("nosb_c3", 1'b0, 3'd4, 8'h44);
      end
      set_rsv(1'b0, 3'd0);
      tick();

      // Reset mid-operation discards the in-flight write
      set_alu(1'b1, 3'd6, 8'h3C);
      set_rsv(1'b1, 3'd7);
      tick();
      check_wr("rst_mid_wr", 1'b1, 3'd6, 8'h3C);
      check("rst_mid_pending", bus.pending, SbEn ? 8'h80 : 8'h00);
      set_alu(1'b0, 3'd0, 8'h00);
      set_rsv(1'b0, 3'd0);
      #2 rst = 1'b0;
      #1;
      check_wr("rst_async", 1'b0, 3'd0, 8'h00);
      check("rst_async_pending", bus.pending, 8'h00);
      #2 rst = 1'b1;
      tick();
      check_wr("post_rst_1", 1'b0, 3'd0, 8'h00);
      tick();
      check_wr("post_rst_2", 1'b0, 3'd0, 8'h00);
      // Pointer was on mem before reset; reset returns it to ALU
      set_alu(1'b1, 3'd1, 8'h9A);
      set_mem(1'b1, 3'd2, 8'hB4);
      #1;
      check_rdy("post_rst_prio", 1'b1, 1'b0);
      tick();
      check_wr("post_rst_wr", 1'b1, 3'd1, 8'h9A);
      set_alu(1'b0, 3'd0, 8'h00);
      set_mem(1'b0, 3'd0, 8'h00);
      tick();
      check_wr("post_rst_idle", 1'b0, 3'd1, 8'h9A);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-003 SHALL have ports alu_valid in 1, alu_addr in 3, alu_data in 8, alu_ready out 1: ALU writeback requester.
REQ-004 SHALL have ports mem_valid in 1, mem_addr in 3, mem_data in 8, mem_ready out 1: load writeback requester.
REQ-005 SHALL have ports we3 out 1, wa3 out 3, wd3 out 8: register-file write port drive, all registered.
REQ-006 SHALL have ports rsv_valid in 1, rsv_addr in 3: issue-stage destination reservation.
REQ-007 SHALL have port pending out 8: per-register outstanding-write mask, bit i = register xi.

Function
REQ-008 SHALL grant at most one requester per cycle; handshake = valid && ready on the same edge.
REQ-009 SHALL drive ready combinationally: only one valid -> that requester ready=1; both valid -> the one holding priority ready=1, other 0; neither valid -> both 0.
REQ-010 SHALL keep a 1-bit round-robin pointer: after an ALU handshake mem holds priority; after a mem handshake ALU holds priority; no handshake -> pointer holds.
REQ-011 SHALL NOT let ready depend on the other requester's ready; valid de-assertion without handshake is legal, no state change.
REQ-012 SHALL on handshake load wa3<=addr, wd3<=data and we3<=1 at that edge, so the write reaches the register file exactly 1 cycle after handshake.
REQ-013 SHALL on handshake with addr==0 still complete the handshake (ready=1) but load we3<=0; wa3/wd3 still load.
REQ-014 SHALL load we3<=0 in any cycle with no handshake; wa3/wd3 hold previous values.
REQ-015 SHALL accept back-to-back handshakes every cycle; sustained throughput 1 write/cycle, no bubbles.
REQ-016 SHALL alternate grants strictly when both requesters stay valid (ALU, mem, ALU, ...).
REQ-017 SHALL set pending[rsv_addr] at the edge where rsv_valid=1 and rsv_addr!=0.
REQ-018 SHALL clear pending[a] at the handshake edge for address a (a!=0).
REQ-019 SHALL, when set and clear target the same register on the same edge, leave the bit set (new reservation wins); set and clear on different registers both take effect.
REQ-020 SHALL hold pending[0]=0 at all times; clearing an already-clear bit is a no-op.

Reset
REQ-021 SHALL while rst=0 force we3=0, wa3=0, wd3=0, pending=8'h00, priority pointer=ALU, independent of clk.
REQ-022 SHALL drive alu_ready=mem_ready=0 while rst=0.
REQ-023 SHALL discard any in-flight write when reset asserts mid-operation; no write issued after release until a new handshake.
REQ-024 SHALL resume arbitration on the first rising clk edge after rst returns to 1.

Configuration
REQ-025 SHALL compile the reservation scoreboard only when macro REGFILE_WB_SCOREBOARD_EN is defined.
REQ-026 SHALL, with REGFILE_WB_SCOREBOARD_EN defined, implement REQ-017..REQ-020.
REQ-027 SHALL, without REGFILE_WB_SCOREBOARD_EN, tie pending to 8'h00, ignore rsv_valid/rsv_addr, and keep all other behaviour identical.

Verification
REQ-028 SHALL cover: only alu_valid=1, addr=3, data=8'hA5 -> alu_ready=1; next cycle we3=1, wa3=3, wd3=8'hA5; following cycle we3=0.
REQ-029 SHALL cover: both valid 4 cycles from reset, ALU addr=1 data=8'h11, mem addr=2 data=8'h22 -> we3 pulses carry 1/11, 2/22, 1/11, 2/22 on consecutive cycles.
REQ-030 SHALL cover: mem_valid=1, addr=0, data=8'hFF -> mem_ready=1, we3 stays 0, wa3=0, wd3=8'hFF next cycle.
REQ-031 SHALL cover (macro defined): rsv addr=5 -> pending=8'h20; ALU writes addr 5 while rsv addr=5 same edge -> pending stays 8'h20; next ALU write addr 5 alone -> pending=8'h00.
REQ-032 SHALL cover: handshake addr=6 data=8'h3C, rst driven 0 before next edge -> we3, wa3, wd3, pending immediately 0; after release, no write until new handshake.
REQ-033 SHALL cover (macro undefined): rsv_valid=1 addr=4 for 3 cycles -> pending=8'h00 throughout; writes unaffected.
